// File: rtl/dmem_bus_if.sv
// Data-memory bus between the Stage 2 access unit and data memory.
// Request channel : mem_req_valid / mem_req_ready handshake carrying
//                   mem_addr, mem_we, mem_wmask, mem_wdata.
// Response channel: mem_resp_valid qualifies mem_rdata (loads only).
// The master modport belongs to the access unit; the slave modport belongs to memory.
interface dmem_bus_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req_valid, mem_addr, mem_we, mem_wmask, mem_wdata,
      input  mem_req_ready, mem_resp_valid, mem_rdata
   );

   modport slave (
      input  mem_req_valid, mem_addr, mem_we, mem_wmask, mem_wdata,
      output mem_req_ready, mem_resp_valid, mem_rdata
   );
endinterface

// File: rtl/dmem_access_unit.sv
// Stage 2 data-memory access unit.
// Decodes the Stage 2 instruction, issues one aligned load or store per
// instruction over the request channel, waits for the load response, and
// stalls the pipeline until the access finishes. The captured load word is
// handed to Stage 3 unshifted on raw_dmem; Stage 3 extracts bytes/halves.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   stage2_inst     : instruction in Stage 2 (opcode and funct3 decoded here)
//   stage2_valid    : Stage 2 holds a live instruction
//   stage2_alu_out  : effective address
//   stage2_rs2      : store source data
//   bus             : data-memory bus (master side)
//   raw_dmem        : last captured load word (or ERR_DATA after a load timeout)
//   stall           : freeze PC and Stage 1/2 registers
//   misaligned      : one-cycle pulse, the cycle after a misaligned access is seen
//   bus_err         : one-cycle pulse when an access is abandoned on timeout
module dmem_access_unit #(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] stage2_inst,
   input  logic        stage2_valid,
   input  logic [31:0] stage2_alu_out,
   input  logic [31:0] stage2_rs2,
   dmem_bus_if.master  bus,
   output logic [31:0] raw_dmem,
   output logic        stall,
   output logic        misaligned,
   output logic        bus_err
);

   localparam int         CW       = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t        state;
   state_t        next_state;

   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic [1:0]    size;
   logic          is_load;
   logic          is_store;
   logic          is_mem;
   logic          mis_det;
   logic          trigger;

   logic [3:0]    fmt_wmask;
   logic [31:0]   fmt_wdata;

   logic [CW-1:0] tmo_cnt;
   logic          expired;

   logic          req_valid;
   logic          take_resp;
   logic          timeout;

   logic [31:0]   addr_q;
   logic          we_q;
   logic [3:0]    wmask_q;
   logic [31:0]   wdata_q;

   logic          unused_inst_bits;

   assign unused_inst_bits = ^{stage2_inst[31:15], stage2_inst[11:7]};

   // Decode the Stage 2 instruction into load/store, access size and
   // alignment. Illegal funct3 values fall out as non-memory instructions,
   // so they never stall and never flag misalignment. A trigger is only
   // possible from IDLE, which is what keeps DONE from re-issuing the same
   // instruction while the pipeline advances past it.
   always_comb begin
      opcode   = stage2_inst[6:0];
      funct3   = stage2_inst[14:12];
      size     = funct3[1:0];
      is_load  = 1'b0;
      is_store = 1'b0;
      mis_det  = 1'b0;
      if (opcode == OP_LOAD) begin
         case (funct3)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: is_load = 1'b1;
            default:                      is_load = 1'b0;
         endcase
      end
      if (opcode == OP_STORE) begin
         case (funct3)
            3'd0, 3'd1, 3'd2: is_store = 1'b1;
            default:          is_store = 1'b0;
         endcase
      end
      is_mem = is_load | is_store;
      case (size)
         2'd1:    mis_det = stage2_alu_out[0];
         2'd2:    mis_det = (stage2_alu_out[1:0] != 2'b00);
         default: mis_det = 1'b0;
      endcase
      trigger = (state == IDLE) && stage2_valid && is_mem && !mis_det;
   end

   // Store formatting: the byte/half is replicated across every lane and
   // the write mask selects the lane(s) chosen by the low address bits.
   // Loads never write, so their mask and data are zero.
   always_comb begin
      fmt_wmask = 4'b0000;
      fmt_wdata = 32'h0000_0000;
      if (is_store) begin
         case (size)
            2'd0: begin
               fmt_wmask = 4'b0001 << stage2_alu_out[1:0];
               fmt_wdata = {4{stage2_rs2[7:0]}};
            end
            2'd1: begin
               fmt_wmask = 4'b0011 << stage2_alu_out[1:0];
               fmt_wdata = {2{stage2_rs2[15:0]}};
            end
            default: begin
               fmt_wmask = 4'hF;
               fmt_wdata = stage2_rs2;
            end
         endcase
      end
   end

   assign expired = (tmo_cnt >= CW'(TIMEOUT_CYCLES - 1));

   // State register for the access sequencer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control decode. A handshake or a response seen in the
   // expiry cycle completes normally; the timeout only fires when neither
   // arrived. Responses are ignored outside WAIT, including the handshake
   // cycle itself.
   always_comb begin
      next_state = state;
      stall      = 1'b0;
      req_valid  = 1'b0;
      take_resp  = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) begin
               stall      = 1'b1;
               next_state = REQ;
            end
         end
         REQ: begin
            stall     = 1'b1;
            req_valid = 1'b1;
            if (bus.mem_req_ready) begin
               next_state = we_q ? DONE : WAIT;
            end else if (expired) begin
               timeout    = 1'b1;
               next_state = DONE;
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (bus.mem_resp_valid) begin
               take_resp  = 1'b1;
               next_state = DONE;
            end else if (expired) begin
               timeout    = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Request fields are captured on the trigger and held untouched until
   // the next trigger, so they stay stable for the whole REQ phase. The
   // timeout counter restarts on each trigger and counts REQ/WAIT cycles.
   // raw_dmem only moves on a completed or abandoned load.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= 32'h0000_0000;
         we_q       <= 1'b0;
         wmask_q    <= 4'b0000;
         wdata_q    <= 32'h0000_0000;
         tmo_cnt    <= '0;
         raw_dmem   <= 32'h0000_0000;
         misaligned <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         misaligned <= (state == IDLE) && stage2_valid && is_mem && mis_det;
         bus_err    <= timeout;
         if (trigger) begin
            addr_q  <= {stage2_alu_out[31:2], 2'b00};
            we_q    <= is_store;
            wmask_q <= fmt_wmask;
            wdata_q <= fmt_wdata;
            tmo_cnt <= '0;
         end else if ((state == REQ) || (state == WAIT)) begin
            tmo_cnt <= tmo_cnt + CW'(1);
         end
         if (take_resp) begin
            raw_dmem <= bus.mem_rdata;
         end else if (timeout && !we_q) begin
            raw_dmem <= ERR_DATA;
         end
      end
   end

   assign bus.mem_req_valid = req_valid;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_we        = we_q;
   assign bus.mem_wmask     = wmask_q;
   assign bus.mem_wdata     = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Testbench for dmem_access_unit.
// Main instance (TIMEOUT_CYCLES=64) is driven with directed instructions
// while a responder process plays memory; expected bus events are queued
// by the stimulus and popped by an independent monitor. A second instance
// (TIMEOUT_CYCLES=4, ERR_DATA=0xDEADDEAD) exercises the timeout path.
module tb_dmem_access_unit;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam int EV_REQ   = 0;
   localparam int EV_DONE  = 1;
   localparam int EV_MISAL = 2;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wmask;
      logic [31:0] wdata;
      logic [31:0] raw;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] stage2_inst;
   logic        stage2_valid;
   logic [31:0] stage2_alu_out;
   logic [31:0] stage2_rs2;
   logic [31:0] raw_dmem;
   logic        stall;
   logic        misaligned;
   logic        bus_err;

   logic [31:0] to_inst;
   logic        to_valid;
   logic [31:0] to_alu;
   logic [31:0] to_rs2;
   logic [31:0] to_raw;
   logic        to_stall;
   logic        to_mis;
   logic        to_berr;

   int          n_vec = 0;
   int          n_err = 0;
   exp_t        exp_q[$];

   int          ready_delay = 0;
   int          resp_delay  = 1;
   logic [31:0] resp_data   = 32'h0;
   logic        stray_resp  = 1'b0;
   logic [31:0] stray_data  = 32'h0;

   dmem_bus_if bus ();
   dmem_bus_if to_bus ();

   always #5 clk = ~clk;

   dmem_access_unit #(.TIMEOUT_CYCLES(64), .ERR_DATA(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .stage2_inst(stage2_inst), .stage2_valid(stage2_valid),
      .stage2_alu_out(stage2_alu_out), .stage2_rs2(stage2_rs2),
      .bus(bus),
      .raw_dmem(raw_dmem), .stall(stall), .misaligned(misaligned), .bus_err(bus_err)
   );

   dmem_access_unit #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_DEAD)) dut_to (
      .clk(clk), .reset(reset),
      .stage2_inst(to_inst), .stage2_valid(to_valid),
      .stage2_alu_out(to_alu), .stage2_rs2(to_rs2),
      .bus(to_bus),
      .raw_dmem(to_raw), .stall(to_stall), .misaligned(to_mis), .bus_err(to_berr)
   );

   function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3);
      return {17'b0, f3, 5'd0, op};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
      end
   endtask

   task automatic pushReq(input logic [31:0] addr, input logic we, input logic [3:0] wmask, input logic [31:0] wdata);
      exp_t e;
      e.kind = EV_REQ; e.addr = addr; e.we = we; e.wmask = wmask; e.wdata = wdata; e.raw = 32'h0;
      exp_q.push_back(e);
   endtask

   task automatic pushDone(input logic [31:0] raw);
      exp_t e;
      e.kind = EV_DONE; e.addr = 32'h0; e.we = 1'b0; e.wmask = 4'h0; e.wdata = 32'h0; e.raw = raw;
      exp_q.push_back(e);
   endtask

   task automatic pushMisal();
      exp_t e;
      e.kind = EV_MISAL; e.addr = 32'h0; e.we = 1'b0; e.wmask = 4'h0; e.wdata = 32'h0; e.raw = 32'h0;
      exp_q.push_back(e);
   endtask

   task automatic popEvent(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("[TB] FAIL unexpected_event: actual kind %0d, required none", kind);
         return;
      end
      e = exp_q.pop_front();
      checkOutput("event_kind", 32'(kind), 32'(e.kind));
      if (kind != e.kind) return;
      if (kind == EV_REQ) begin
         checkOutput("req_addr", bus.mem_addr, e.addr);
         checkOutput("req_we", {31'b0, bus.mem_we}, {31'b0, e.we});
         checkOutput("req_wmask", {28'b0, bus.mem_wmask}, {28'b0, e.wmask});
         if (e.we) checkOutput("req_wdata", bus.mem_wdata, e.wdata);
      end else if (kind == EV_DONE) begin
         checkOutput("done_raw_dmem", raw_dmem, e.raw);
         checkOutput("done_bus_err", {31'b0, bus_err}, 32'h0);
      end
   endtask

   // Memory model for the main instance: ready after ready_delay REQ
   // cycles, then a load response resp_delay cycles after the handshake.
   initial begin
      int   req_cycles;
      int   wait_cnt;
      logic pend;
      req_cycles = 0;
      wait_cnt   = 0;
      pend       = 1'b0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         bus.mem_req_ready  = 1'b0;
         bus.mem_resp_valid = 1'b0;
         if (reset) begin
            pend       = 1'b0;
            req_cycles = 0;
         end else if (stray_resp) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = stray_data;
         end else if (pend) begin
            if (wait_cnt == 0) begin
               bus.mem_resp_valid = 1'b1;
               bus.mem_rdata      = resp_data;
               pend               = 1'b0;
            end else begin
               wait_cnt--;
            end
         end else if (bus.mem_req_valid) begin
            if (req_cycles == ready_delay) begin
               bus.mem_req_ready = 1'b1;
               req_cycles        = 0;
               if (!bus.mem_we) begin
                  pend     = 1'b1;
                  wait_cnt = resp_delay - 1;
               end
            end else begin
               req_cycles++;
            end
         end
      end
   end

   // Monitor: pops an expected event for every handshake, every DONE
   // (stall falling) and every misaligned pulse, and checks that request
   // fields hold steady while a request waits for ready.
   initial begin
      logic        prev_stall;
      logic        prev_wait;
      logic [31:0] snap_addr;
      logic [31:0] snap_wdata;
      logic [4:0]  snap_ctl;
      prev_stall = 1'b0;
      prev_wait  = 1'b0;
      snap_addr  = 32'h0;
      snap_wdata = 32'h0;
      snap_ctl   = 5'h0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 1'b0;
            prev_wait  = 1'b0;
         end else begin
            if (misaligned) popEvent(EV_MISAL);
            if (bus.mem_req_valid && prev_wait) begin
               checkOutput("req_addr_stable", bus.mem_addr, snap_addr);
               checkOutput("req_wdata_stable", bus.mem_wdata, snap_wdata);
               checkOutput("req_ctl_stable", {27'b0, bus.mem_we, bus.mem_wmask}, {27'b0, snap_ctl});
            end
            if (bus.mem_req_valid) begin
               snap_addr  = bus.mem_addr;
               snap_wdata = bus.mem_wdata;
               snap_ctl   = {bus.mem_we, bus.mem_wmask};
            end
            if (bus.mem_req_valid && bus.mem_req_ready) popEvent(EV_REQ);
            if (prev_stall && !stall) popEvent(EV_DONE);
            prev_stall = stall;
            prev_wait  = bus.mem_req_valid && !bus.mem_req_ready;
         end
      end
   end

   // Present one instruction in Stage 2 and hold it while stall is high,
   // as the real pipeline would; returns the stall and request-valid cycle counts.
   task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] rs2,
                                output int stall_cycles, output int req_cycles);
      @(posedge clk);
      #1;
      stage2_valid   = 1'b1;
      stage2_inst    = inst;
      stage2_alu_out = addr;
      stage2_rs2     = rs2;
      stall_cycles   = 0;
      req_cycles     = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.mem_req_valid) req_cycles++;
         if (stall) stall_cycles++;
         else return;
      end
      n_vec++;
      n_err++;
      $display("[TB] FAIL stall_bound: actual stall still high after 200 cycles, required release");
   endtask

   task automatic bubble();
      @(posedge clk);
      #1;
      stage2_valid = 1'b0;
      @(negedge clk);
   endtask

   // Drive the timeout instance; ready is raised during REQ cycle ready_at
   // (0 = never). Memory never responds on this instance.
   task automatic runTimeout(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] rs2,
                             input int ready_at, output int stall_c, output int req_c, output int berr_c);
      @(posedge clk);
      #1;
      to_valid = 1'b1;
      to_inst  = inst;
      to_alu   = addr;
      to_rs2   = rs2;
      stall_c  = 0;
      req_c    = 0;
      berr_c   = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (to_bus.mem_req_valid) begin
            req_c++;
            to_bus.mem_req_ready = (req_c == ready_at);
         end else begin
            to_bus.mem_req_ready = 1'b0;
         end
         if (to_berr) berr_c++;
         if (to_stall) stall_c++;
         else break;
      end
      @(posedge clk);
      #1;
      to_valid = 1'b0;
      to_bus.mem_req_ready = 1'b0;
      @(negedge clk);
      if (to_berr) berr_c++;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int sc;
      int rc;
      int bc;
      reset          = 1'b1;
      stage2_valid   = 1'b0;
      stage2_inst    = 32'h0;
      stage2_alu_out = 32'h0;
      stage2_rs2     = 32'h0;
      to_valid       = 1'b0;
      to_inst        = 32'h0;
      to_alu         = 32'h0;
      to_rs2         = 32'h0;
      to_bus.mem_req_ready  = 1'b0;
      to_bus.mem_resp_valid = 1'b0;
      to_bus.mem_rdata      = 32'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rst_raw_dmem", raw_dmem, 32'h0);
      checkOutput("rst_stall", {31'b0, stall}, 32'h0);
      checkOutput("rst_req_valid", {31'b0, bus.mem_req_valid}, 32'h0);
      checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
      checkOutput("rst_we_wmask", {27'b0, bus.mem_we, bus.mem_wmask}, 32'h0);
      checkOutput("rst_wdata", bus.mem_wdata, 32'h0);
      checkOutput("rst_flags", {30'b0, misaligned, bus_err}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] LW 0x100");
      ready_delay = 0; resp_delay = 2; resp_data = 32'hCAFE_BABE;
      pushReq(32'h100, 1'b0, 4'h0, 32'h0);
      pushDone(32'hCAFE_BABE);
      applyStimulus(mk_inst(OP_LOAD, 3'd2), 32'h100, 32'h0, sc, rc);
      checkOutput("lw_stall_cycles", 32'(sc), 32'd4);
      checkOutput("lw_req_cycles", 32'(rc), 32'd1);

      $display("[TB] SB 0x203 / SH 0x202");
      pushReq(32'h200, 1'b1, 4'b1000, 32'hABAB_ABAB);
      pushDone(32'hCAFE_BABE);
      applyStimulus(mk_inst(OP_STORE, 3'd0), 32'h203, 32'h1234_56AB, sc, rc);
      checkOutput("sb_stall_cycles", 32'(sc), 32'd2);
      pushReq(32'h200, 1'b1, 4'b1100, 32'hBEEF_BEEF);
      pushDone(32'hCAFE_BABE);
      applyStimulus(mk_inst(OP_STORE, 3'd1), 32'h202, 32'h0000_BEEF, sc, rc);
      checkOutput("sh_stall_cycles", 32'(sc), 32'd2);

      $display("[TB] misaligned LW 0x102 / LH 0x101");
      pushMisal();
      applyStimulus(mk_inst(OP_LOAD, 3'd2), 32'h102, 32'h0, sc, rc);
      checkOutput("mis_lw_stall", 32'(sc), 32'd0);
      checkOutput("mis_lw_req", 32'(rc), 32'd0);
      pushMisal();
      applyStimulus(mk_inst(OP_LOAD, 3'd1), 32'h101, 32'h0, sc, rc);
      checkOutput("mis_lh_stall", 32'(sc), 32'd0);
      checkOutput("mis_lh_req", 32'(rc), 32'd0);
      bubble();
      bubble();
      checkOutput("mis_raw_kept", raw_dmem, 32'hCAFE_BABE);

      $display("[TB] SW 0x300, ready after 5 cycles");
      ready_delay = 5;
      pushReq(32'h300, 1'b1, 4'hF, 32'h1122_3344);
      pushDone(32'hCAFE_BABE);
      applyStimulus(mk_inst(OP_STORE, 3'd2), 32'h300, 32'h1122_3344, sc, rc);
      checkOutput("slow_ready_stall", 32'(sc), 32'd7);
      checkOutput("slow_ready_req", 32'(rc), 32'd6);
      ready_delay = 0;

      $display("[TB] LBU 0x105 minimum latency");
      resp_delay = 1; resp_data = 32'h8899_AABB;
      pushReq(32'h104, 1'b0, 4'h0, 32'h0);
      pushDone(32'h8899_AABB);
      applyStimulus(mk_inst(OP_LOAD, 3'd4), 32'h105, 32'h0, sc, rc);
      checkOutput("lbu_stall_cycles", 32'(sc), 32'd3);

      $display("[TB] back-to-back LW then SW");
      resp_data = 32'h0BAD_F00D;
      pushReq(32'h108, 1'b0, 4'h0, 32'h0);
      pushDone(32'h0BAD_F00D);
      pushReq(32'h10C, 1'b1, 4'hF, 32'hA5A5_A5A5);
      pushDone(32'h0BAD_F00D);
      applyStimulus(mk_inst(OP_LOAD, 3'd2), 32'h108, 32'h0, sc, rc);
      checkOutput("b2b_lw_stall", 32'(sc), 32'd3);
      checkOutput("b2b_lw_req", 32'(rc), 32'd1);
      applyStimulus(mk_inst(OP_STORE, 3'd2), 32'h10C, 32'hA5A5_A5A5, sc, rc);
      checkOutput("b2b_sw_stall", 32'(sc), 32'd2);
      checkOutput("b2b_sw_req", 32'(rc), 32'd1);

      $display("[TB] illegal funct3 treated as non-memory");
      applyStimulus(mk_inst(OP_LOAD, 3'd3), 32'h101, 32'h0, sc, rc);
      checkOutput("ill_load_stall", 32'(sc), 32'd0);
      applyStimulus(mk_inst(OP_STORE, 3'd4), 32'h102, 32'h0, sc, rc);
      checkOutput("ill_store_req", 32'(rc), 32'd0);
      bubble();
      bubble();

      $display("[TB] reset during WAIT");
      resp_delay = 1000;
      pushReq(32'h400, 1'b0, 4'h0, 32'h0);
      @(posedge clk);
      #1;
      stage2_valid   = 1'b1;
      stage2_inst    = mk_inst(OP_LOAD, 3'd2);
      stage2_alu_out = 32'h400;
      repeat (3) @(negedge clk);
      checkOutput("wait_stall", {31'b0, stall}, 32'h1);
      @(posedge clk);
      #1;
      reset        = 1'b1;
      stage2_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset      = 1'b0;
      stray_resp = 1'b1;
      stray_data = 32'h5555_5555;
      @(posedge clk);
      #1;
      stray_resp = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_raw", raw_dmem, 32'h0);
      checkOutput("post_rst_stall", {31'b0, stall}, 32'h0);
      checkOutput("post_rst_req_valid", {31'b0, bus.mem_req_valid}, 32'h0);
      checkOutput("post_rst_addr", bus.mem_addr, 32'h0);
      checkOutput("post_rst_ctl", {27'b0, bus.mem_we, bus.mem_wmask}, 32'h0);
      checkOutput("post_rst_wdata", bus.mem_wdata, 32'h0);
      checkOutput("post_rst_flags", {30'b0, misaligned, bus_err}, 32'h0);
      resp_delay = 1;

      $display("[TB] timeout instance");
      runTimeout(mk_inst(OP_LOAD, 3'd2), 32'h40, 32'h0, 0, sc, rc, bc);
      checkOutput("tmo_load_stall", 32'(sc), 32'd5);
      checkOutput("tmo_load_req", 32'(rc), 32'd4);
      checkOutput("tmo_load_berr", 32'(bc), 32'd1);
      checkOutput("tmo_load_raw", to_raw, 32'hDEAD_DEAD);
      runTimeout(mk_inst(OP_STORE, 3'd2), 32'h44, 32'h7777_0000, 4, sc, rc, bc);
      checkOutput("tmo_edge_stall", 32'(sc), 32'd5);
      checkOutput("tmo_edge_req", 32'(rc), 32'd4);
      checkOutput("tmo_edge_berr", 32'(bc), 32'd0);
      checkOutput("tmo_edge_raw", to_raw, 32'hDEAD_DEAD);

      repeat (4) @(negedge clk);
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
